// File: rtl/residue_pkg.sv
// Shared definitions for the mod-3 residue encoder/checker pair.
package residue_pkg;

  // Residue code points; zero has two encodings.
  localparam logic [1:0] RES0_A = 2'b00;
  localparam logic [1:0] RES0_B = 2'b11;
  localparam logic [1:0] RES1   = 2'b01;
  localparam logic [1:0] RES2   = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StDone
  } state_e;

  // Map the alternate zero code onto the canonical one.
  function automatic logic [1:0] canon_res(logic [1:0] r);
    return (r == RES0_B) ? RES0_A : r;
  endfunction

  // (a + b) mod 3; tolerant of a faulted 11 operand.
  function automatic logic [1:0] add_mod3(logic [1:0] a, logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/residue_check_mod3_if.sv
// Word-in / result-out handshake bundle for the residue checker.
interface residue_check_mod3_if #(
  parameter int unsigned W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_res;
  logic         out_valid;
  logic         out_ready;
  logic         out_err;
  logic [1:0]   out_res;

  modport master (
    output in_valid, in_data, in_res, out_ready,
    input  in_ready, out_valid, out_err, out_res
  );

  modport slave (
    input  in_valid, in_data, in_res, out_ready,
    output in_ready, out_valid, out_err, out_res
  );
endinterface

// File: rtl/residue_digit_mod3.sv
// One serial step: fold a 2-bit base-4 digit into a mod-3 accumulator.
module residue_digit_mod3
  import residue_pkg::*;
(
  input  logic [1:0] d,
  input  logic [1:0] acc,
  input  logic [1:0] fault_en,
  input  logic       fault_val,
  output logic [1:0] acc_next
);

  logic [1:0] digit;
  logic [1:0] sum;

  // 4 == 1 (mod 3), so each base-4 digit contributes its own value mod 3.
  always_comb begin
    digit       = (d == 2'b11) ? 2'b00 : d;
    sum         = add_mod3(acc, digit);
    acc_next[0] = fault_en[0] ? fault_val : sum[0];
    acc_next[1] = fault_en[1] ? fault_val : sum[1];
  end

endmodule

// File: rtl/residue_check_mod3.sv
// Serial mod-3 residue checker with sticky flag and saturating error counter.
module residue_check_mod3
  import residue_pkg::*;
#(
  parameter int unsigned W        = 16,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned NG       = 128,
  parameter int unsigned GID_BASE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  residue_check_mod3_if.slave  bus,
  output logic                 err_flag,
  output logic [CNT_W-1:0]     err_cnt,
  input  logic                 clr_err,
  input  logic [NG-1:0]        fault_en_bus,
  input  logic                 fault_val
);

  localparam int unsigned NPairs = W / 2;
  localparam int unsigned PairW  = $clog2(NPairs + 1);
  localparam logic [PairW-1:0] LastPair = PairW'(NPairs);

  state_e             state_q, state_d;
  logic [W-1:0]       shift_q, shift_d;
  logic [1:0]         res_q, res_d;
  logic [1:0]         acc_q, acc_d, acc_step;
  logic [PairW-1:0]   pair_q, pair_d;
  logic               err_flag_q, err_flag_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               accept, stepping, compute_end, mismatch;
  logic               unused_fault;

  // Only three bits of the shared fault bus belong to this instance.
  assign unused_fault = ^fault_en_bus;

  assign accept      = (state_q == StIdle) && bus.in_valid;
  assign stepping    = (state_q == StCompute) && (pair_q != LastPair);
  assign compute_end = (state_q == StCompute) && (pair_q == LastPair);
  assign mismatch    = (acc_q != res_q);

  residue_digit_mod3 u_digit (
    .d         (shift_q[1:0]),
    .acc       (acc_q),
    .fault_en  (fault_en_bus[GID_BASE+1:GID_BASE]),
    .fault_val (fault_val),
    .acc_next  (acc_step)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state; the extra COMPUTE cycle after the last pair does the bookkeeping.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.in_valid) state_d = StCompute;
      StCompute: if (pair_q == LastPair) state_d = StDone;
      StDone:    if (bus.out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs; out_err carries its own fault site.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.out_res   = acc_q;
    bus.out_err   = fault_en_bus[GID_BASE+2] ? fault_val : mismatch;
  end

  // Datapath next state: latch on accept, shift/accumulate while pairs remain.
  always_comb begin
    shift_d = shift_q;
    res_d   = res_q;
    acc_d   = acc_q;
    pair_d  = pair_q;
    if (accept) begin
      shift_d = bus.in_data;
      res_d   = canon_res(bus.in_res);
      acc_d   = 2'b00;
      pair_d  = '0;
    end else if (stepping) begin
      shift_d = shift_q >> 2;
      acc_d   = acc_step;
      pair_d  = pair_q + PairW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      res_q   <= 2'b00;
      acc_q   <= 2'b00;
      pair_q  <= '0;
    end else begin
      shift_q <= shift_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      pair_q  <= pair_d;
    end
  end

  // Error bookkeeping on COMPUTE->DONE; clear wins over a same-cycle increment.
  always_comb begin
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    if (clr_err) begin
      err_flag_d = 1'b0;
      err_cnt_d  = '0;
    end else if (compute_end && mismatch) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Error bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_residue_check_mod3.sv
// Directed, table-driven bench for residue_check_mod3 (W=16; second copy with CNT_W=2).
module tb_residue_check_mod3;
  import residue_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned NG = 128;

  logic            clk;
  logic            rst;
  logic            clr_err;
  logic            clr_err2;
  logic [NG-1:0]   fault_en_bus;
  logic            fault_val;
  logic            err_flag, err_flag2;
  logic [7:0]      err_cnt;
  logic [1:0]      err_cnt2;

  residue_check_mod3_if #(.W(W)) bus_a ();
  residue_check_mod3_if #(.W(W)) bus_b ();

  // Second copy sees identical traffic but has a 2-bit counter.
  assign bus_b.in_valid  = bus_a.in_valid;
  assign bus_b.in_data   = bus_a.in_data;
  assign bus_b.in_res    = bus_a.in_res;
  assign bus_b.out_ready = bus_a.out_ready;

  residue_check_mod3 #(.W(W), .CNT_W(8), .NG(NG), .GID_BASE(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_a),
    .err_flag     (err_flag),
    .err_cnt      (err_cnt),
    .clr_err      (clr_err),
    .fault_en_bus (fault_en_bus),
    .fault_val    (fault_val)
  );

  residue_check_mod3 #(.W(W), .CNT_W(2), .NG(NG), .GID_BASE(0)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_b),
    .err_flag     (err_flag2),
    .err_cnt      (err_cnt2),
    .clr_err      (clr_err2),
    .fault_en_bus (fault_en_bus),
    .fault_val    (fault_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference bookkeeping
  logic exp_flag;
  int   exp_cnt;
  int   exp_cnt2;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  res;
    logic [1:0]  exp_res;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic update_model(input logic mism, input logic clr);
    if (clr) begin
      exp_flag = 1'b0;
      exp_cnt  = 0;
    end else if (mism) begin
      exp_flag = 1'b1;
      if (exp_cnt < 255) exp_cnt++;
    end
    if (mism && exp_cnt2 < 3) exp_cnt2++;
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge with in_valid low.
  task automatic accept_word(input logic [15:0] data, input logic [1:0] res);
    logic rdy;
    int   n;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = data;
    bus_a.in_res   = res;
    n = 0;
    do begin
      rdy = bus_a.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 20);
    bus_a.in_valid = 1'b0;
    check("accept", {31'd0, rdy}, 32'd1);
  endtask

  task automatic wait_result(input string name, input logic [1:0] exp_res, input logic exp_err,
                             input logic mism, input logic clr, input int hold, input logic hs);
    int   k;
    logic got;
    k   = 0;
    got = 1'b0;
    while (!got && k < 30) begin
      if (clr && k == 8) clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
      k++;
      got = bus_a.out_valid;
    end
    check({name, "_latency"}, k, 9);
    update_model(mism, clr);
    check({name, "_res"}, {30'd0, bus_a.out_res}, {30'd0, exp_res});
    check({name, "_err"}, {31'd0, bus_a.out_err}, {31'd0, exp_err});
    check({name, "_flag"}, {31'd0, err_flag}, {31'd0, exp_flag});
    check({name, "_cnt"}, {24'd0, err_cnt}, exp_cnt);
    check({name, "_cnt2"}, {30'd0, err_cnt2}, exp_cnt2);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, "_hold_valid"}, {31'd0, bus_a.out_valid}, 32'd1);
      check({name, "_hold_res"}, {30'd0, bus_a.out_res}, {30'd0, exp_res});
      check({name, "_hold_err"}, {31'd0, bus_a.out_err}, {31'd0, exp_err});
      check({name, "_hold_ready"}, {31'd0, bus_a.in_ready}, 32'd0);
    end
    if (hs) begin
      bus_a.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_a.out_ready = 1'b0;
      check({name, "_ready_after"}, {31'd0, bus_a.in_ready}, 32'd1);
      check({name, "_valid_after"}, {31'd0, bus_a.out_valid}, 32'd0);
    end
  endtask

  task automatic run_word(input string name, input logic [15:0] data, input logic [1:0] res,
                          input logic [1:0] exp_res, input logic exp_err, input logic mism,
                          input logic clr, input int hold);
    accept_word(data, res);
    wait_result(name, exp_res, exp_err, mism, clr, hold, 1'b1);
  endtask

  initial begin
    logic [1:0] r;
    vecs[0] = '{16'd7,      2'b01, 2'b01, 1'b0};
    vecs[1] = '{16'd9,      2'b11, 2'b00, 1'b0};
    vecs[2] = '{16'd9,      2'b00, 2'b00, 1'b0};
    vecs[3] = '{16'd10,     2'b10, 2'b01, 1'b1};
    vecs[4] = '{16'hFFFF,   2'b00, 2'b00, 1'b0};
    vecs[5] = '{16'h1234,   2'b01, 2'b01, 1'b0};
    vecs[6] = '{16'd5,      2'b01, 2'b10, 1'b1};
    vecs[7] = '{16'hAAAA,   2'b10, 2'b01, 1'b1};
    vecs[8] = '{16'd0,      2'b11, 2'b00, 1'b0};
    vecs[9] = '{16'd1,      2'b10, 2'b01, 1'b1};

    exp_flag        = 1'b0;
    exp_cnt         = 0;
    exp_cnt2        = 0;
    rst             = 1'b1;
    clr_err         = 1'b0;
    clr_err2        = 1'b0;
    fault_en_bus    = '0;
    fault_val       = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.in_data   = '0;
    bus_a.in_res    = 2'b00;
    bus_a.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
    check("rst_out_err", {31'd0, bus_a.out_err}, 32'd0);
    check("rst_out_res", {30'd0, bus_a.out_res}, 32'd0);
    check("rst_err_flag", {31'd0, err_flag}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-COMPUTE discards a mismatching word.
    accept_word(16'd10, 2'b10);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_idle_valid", {31'd0, bus_a.out_valid}, 32'd0);
    check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("midrst_err_flag", {31'd0, err_flag}, 32'd0);

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      run_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].res, vecs[i].exp_res,
               vecs[i].exp_err, vecs[i].exp_err, 1'b0, 0);
    end

    // clr_err coincides with a mismatch: clear wins, out_err still reports it.
    run_word("clr_same_cycle", 16'd2, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 0);
    check("sat_cnt2", {30'd0, err_cnt2}, 32'd3);
    check("sat_flag2", {31'd0, err_flag2}, 32'd1);

    // Backpressure in DONE, then no same-cycle bypass into a new accept.
    accept_word(16'd7, 2'b01);
    wait_result("hold", 2'b01, 1'b0, 1'b0, 1'b0, 5, 1'b0);
    bus_a.in_valid  = 1'b1;
    bus_a.in_data   = 16'd9;
    bus_a.in_res    = 2'b00;
    bus_a.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_a.out_ready = 1'b0;
    check("nobypass_in_ready", {31'd0, bus_a.in_ready}, 32'd1);
    check("nobypass_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
    check("next_accepted", {31'd0, bus_a.in_ready}, 32'd0);
    wait_result("after_bypass", 2'b00, 1'b0, 1'b0, 1'b0, 0, 1'b1);

    // Fault sites
    fault_val       = 1'b1;
    fault_en_bus    = '0;
    fault_en_bus[2] = 1'b1;
    run_word("fault_out_err", 16'd3, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 0);
    fault_en_bus    = '0;
    fault_en_bus[0] = 1'b1;
    run_word("fault_acc0", 16'd0, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 0);
    fault_en_bus    = '0;
    fault_en_bus[5] = 1'b1;
    run_word("fault_foreign", 16'd7, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 0);
    fault_en_bus    = '0;
    fault_val       = 1'b0;

    // Strided sweep with correct residues: no new errors.
    for (int v = 0; v < 65536; v += 97) begin
      r = 2'(v % 3);
      run_word($sformatf("sweep%0d", v), 16'(v), r, r, 1'b0, 1'b0, 1'b0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
